// File: rtl/rf_wb_arbiter_if.sv
// Write-port bus between the two producers, the arbiter and the register file.
// The master side is the environment (producers plus register file); the
// slave side is the arbiter itself.
interface rf_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // Port A: in-order pipeline writeback
    logic            a_valid;
    logic            a_ready;
    logic [AW-1:0]   a_addr;
    logic [XLEN-1:0] a_data;

    // Port B: long-latency unit
    logic            b_valid;
    logic            b_ready;
    logic [AW-1:0]   b_addr;
    logic [XLEN-1:0] b_data;

    // Register file write port and hazard feedback
    logic            regwrite;
    logic [AW-1:0]   writereg_addr;
    logic [XLEN-1:0] writedata;
    logic            stall;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  regwrite, writereg_addr, writedata, stall
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output regwrite, writereg_addr, writedata, stall
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter. Port A (pipeline writeback) has fixed
// priority; a saturating starvation counter force-grants port B after it has
// waited STARVE_MAX consecutive cycles. The register file write port is driven
// from registers, one cycle after the winning handshake.
module rf_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4     // legal range 1..15
) (
    input  logic                 i_clk,
    input  logic                 i_rst,   // asynchronous, active-low
    rf_wb_arbiter_if.slave       bus
);

    typedef enum logic {
        MODE_NORMAL,   // A has priority, B only gets idle cycles
        MODE_FORCE     // B has waited long enough and wins this cycle
    } arb_mode_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]      r_starve;
    logic [3:0]      w_starve_nxt;
    arb_mode_e       w_mode;
    logic            w_a_ready;
    logic            w_b_ready;
    logic            w_a_xfer;
    logic            w_b_xfer;

    logic            r_regwrite;
    logic [AW-1:0]   r_waddr;
    logic [XLEN-1:0] r_wdata;

    // Arbitration: readies from the valids and the starvation count only,
    // so no addr/data path reaches any output combinationally.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // that no path leaves it unassigned, which would infer a latch.
        w_mode       = (r_starve == STARVE_LIM) ? MODE_FORCE : MODE_NORMAL;
        w_a_ready    = 1'b0;
        w_b_ready    = 1'b0;
        w_starve_nxt = r_starve;

        // Both readies are held low while reset is asserted.
        if (i_rst) begin
            case (w_mode)
                MODE_NORMAL: begin
                    w_a_ready = 1'b1;
                    w_b_ready = !bus.a_valid;
                end
                MODE_FORCE: begin
                    w_a_ready = !bus.b_valid;
                    w_b_ready = bus.b_valid;
                end
                default: begin
                    w_a_ready = 1'b0;
                    w_b_ready = 1'b0;
                end
            endcase
        end

        w_a_xfer = bus.a_valid && w_a_ready;
        w_b_xfer = bus.b_valid && w_b_ready;

        // Starvation credit is only kept while B keeps waiting.
        if (!bus.b_valid || w_b_xfer) begin
            w_starve_nxt = 4'd0;
        end else if (r_starve < STARVE_LIM) begin
            w_starve_nxt = r_starve + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!i_rst) begin
            r_starve <= 4'd0;
        end else begin
            r_starve <= w_starve_nxt;
        end
    end

    // Register-file write port: latch the winner; x0 writes handshake but
    // never raise the write enable. Address/data hold when idle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_regwrite <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else if (w_a_xfer) begin
            r_regwrite <= (bus.a_addr != '0);
            r_waddr    <= bus.a_addr;
            r_wdata    <= bus.a_data;
        end else if (w_b_xfer) begin
            r_regwrite <= (bus.b_addr != '0);
            r_waddr    <= bus.b_addr;
            r_wdata    <= bus.b_data;
        end else begin
            r_regwrite <= 1'b0;
        end
    end

    assign bus.a_ready       = w_a_ready;
    assign bus.b_ready       = w_b_ready;
    assign bus.stall         = bus.a_valid && !w_a_ready;
    assign bus.regwrite      = r_regwrite;
    assign bus.writereg_addr = r_waddr;
    assign bus.writedata     = r_wdata;

endmodule
